// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle MIPS-subset datapath (IF/ID/EX/MEM/WB, HALT on fault).
// Latency: strobes and selects are combinational from State plus the latched class; 3-5 cycles per instruction plus memory waits.
// Backpressure: IF and MEM hold until MemReady; MEM_TIMEOUT consecutive unanswered requests halt the FSM.
//
// Optional feature macro: PERF_CNT_EN builds the CycleCnt/RetireCnt counters.
// When PERF_CNT_EN is not defined, both ports read 0.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-low reset
//   Opcode, Funct         IR[31:26] and IR[5:0]; Funct is used only for the R-type legality check
//   Zero, MemReady        ALU zero flag, memory access completes this cycle
//   MemReq..PCSource      datapath strobes and mux selects, all forced to 0 while Reset=0
//   State                 IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=7
//   Retire                one-cycle pulse on the last cycle of each instruction
//   Halted, FaultCode     in HALT; 01 illegal opcode/funct, 10 memory timeout
//   CycleCnt, RetireCnt   performance counters, frozen in HALT
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [2:0]       State,
  output logic             Retire,
  output logic             Halted,
  output logic [1:0]       FaultCode,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] RetireCnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LW   = 3'd1,
    C_SW   = 3'd2,
    C_BEQ  = 3'd3,
    C_J    = 3'd4,
    C_ADDI = 3'd5,
    C_ILL  = 3'd6
  } cls_t;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  // Wide enough to hold MEM_TIMEOUT-1, the largest value reached before halting.
  localparam int          TO_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TO_EN  = (MEM_TIMEOUT > 0);
  localparam logic [31:0] TO_LIM = MEM_TIMEOUT;

  state_t          state, state_nx;
  cls_t            cls, dec_cls;
  logic [1:0]      fault, fault_nx;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     to_cnt_inc;
  logic            mem_wait;
  logic            to_hit;

  // Raw (pre-reset-gating) control values.
  logic       mem_req, iord, mem_read, mem_write, ir_write, pc_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, retire;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // Instruction decode; only consumed in ID, where the class gets latched.
  always_comb begin
    dec_cls = C_ILL;
    case (Opcode)
      6'b000000: begin
        if (Funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          dec_cls = C_R;
      end
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b000010: dec_cls = C_J;
      6'b001000: dec_cls = C_ADDI;
      default:   dec_cls = C_ILL;
    endcase
  end

  // A wait cycle is any memory-phase cycle without MemReady; derived from the
  // state directly so the timeout path does not depend on the output logic.
  assign mem_wait   = ((state == S_IF) || (state == S_MEM)) && !MemReady;
  assign to_cnt_inc = 32'(to_cnt) + 32'd1;
  assign to_hit     = TO_EN && mem_wait && (to_cnt_inc == TO_LIM);

  always_comb begin
    state_nx   = state;
    fault_nx   = fault;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    retire     = 1'b0;

    case (state)
      S_IF: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = MemReady;
        pc_write  = MemReady;
        // MemReady takes priority over a timeout on the same cycle.
        if (MemReady) begin
          state_nx = S_ID;
        end else if (to_hit) begin
          state_nx = S_HALT;
          fault_nx = FLT_TIMEOUT;
        end
      end

      S_ID: begin
        alu_src_b = 2'b11;
        if (dec_cls == C_ILL) begin
          state_nx = S_HALT;
          fault_nx = FLT_ILLEGAL;
        end else begin
          state_nx = S_EX;
        end
      end

      S_EX: begin
        case (cls)
          C_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_nx  = S_WB;
          end
          C_LW, C_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nx  = S_MEM;
          end
          C_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nx  = S_WB;
          end
          C_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            pc_write  = Zero;
            retire    = 1'b1;
            state_nx  = S_IF;
          end
          C_J: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_nx  = S_IF;
          end
          default: state_nx = S_IF;
        endcase
      end

      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = (cls == C_LW);
        mem_write = (cls == C_SW);
        if (MemReady) begin
          if (cls == C_LW) begin
            state_nx = S_WB;
          end else begin
            retire   = 1'b1;
            state_nx = S_IF;
          end
        end else if (to_hit) begin
          state_nx = S_HALT;
          fault_nx = FLT_TIMEOUT;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls == C_R);
        mem_to_reg = (cls == C_LW);
        retire     = 1'b1;
        state_nx   = S_IF;
      end

      S_HALT: state_nx = S_HALT;

      default: state_nx = S_IF;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= S_IF;
      cls    <= C_R;
      fault  <= FLT_NONE;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      fault <= fault_nx;
      if (state == S_ID)
        cls <= dec_cls;
      // Any state change clears the wait count, so both IF and MEM start fresh.
      if (state_nx != state)
        to_cnt <= '0;
      else if (TO_EN && mem_wait)
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Reset overrides every strobe and select in the same cycle it is asserted.
  assign MemReq    = Reset & mem_req;
  assign IorD      = Reset & iord;
  assign MemRead   = Reset & mem_read;
  assign MemWrite  = Reset & mem_write;
  assign IRWrite   = Reset & ir_write;
  assign PCWrite   = Reset & pc_write;
  assign RegWrite  = Reset & reg_write;
  assign RegDst    = Reset & reg_dst;
  assign MemtoReg  = Reset & mem_to_reg;
  assign ALUSrcA   = Reset & alu_src_a;
  assign ALUSrcB   = Reset ? alu_src_b : 2'b00;
  assign ALUOp     = Reset ? alu_op    : 2'b00;
  assign PCSource  = Reset ? pc_source : 2'b00;
  assign Retire    = Reset & retire;
  assign State     = state;
  assign Halted    = (state == S_HALT);
  assign FaultCode = fault;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (state != S_HALT) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign CycleCnt  = cycle_cnt;
  assign RetireCnt = retire_cnt;
`else
  assign CycleCnt  = '0;
  assign RetireCnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scenario tasks for multicycle_ctrl (MEM_TIMEOUT=4).
// Each scenario is a per-cycle plan of inputs plus expected outputs taken from the control tables.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_multicycle_ctrl;

  logic        Clock, Reset, Zero, MemReady;
  logic [5:0]  Opcode, Funct;
  logic        MemReq, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource, FaultCode;
  logic [2:0]  State;
  logic        Retire, Halted;
  logic [31:0] CycleCnt, RetireCnt;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .Retire(Retire),
    .Halted(Halted), .FaultCode(FaultCode), .CycleCnt(CycleCnt), .RetireCnt(RetireCnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111, FN_ADD = 6'b100000, FN_BAD = 6'b000000;

  typedef struct {
    logic        rst, rdy, zero;
    logic [5:0]  op, fn;
    logic [2:0]  st;
    logic [15:0] ctrl;
    logic        ret, hlt;
    logic [1:0]  flt;
  } cyc_t;

  cyc_t sb[$];
  int   total  = 0;
  int   passed = 0;

  logic [15:0] obs_ctrl;
  assign obs_ctrl = {MemReq, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, RegDst,
                     MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Packs strobe values into the same order as obs_ctrl.
  function automatic logic [15:0] cv(input logic mr, io, rd, wr, ir, pw, rw, rdst, m2r, sa,
                                     input logic [1:0] srcb, aop, psrc);
    return {mr, io, rd, wr, ir, pw, rw, rdst, m2r, sa, srcb, aop, psrc};
  endfunction

  function automatic cyc_t cy(input logic rst, rdy, zero, input logic [5:0] op, fn,
                              input logic [2:0] st, input logic [15:0] ctrl,
                              input logic ret, hlt, input logic [1:0] flt);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.zero = zero; c.op = op; c.fn = fn;
    c.st = st; c.ctrl = ctrl; c.ret = ret; c.hlt = hlt; c.flt = flt;
    return c;
  endfunction

  // Expected control words, one per state/class row of the control table.
  function automatic logic [15:0] x_if(input logic r);
    return cv(1, 0, 1, 0, r, r, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] x_id();     return cv(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00); endfunction
  function automatic logic [15:0] x_ex_r();   return cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00); endfunction
  function automatic logic [15:0] x_ex_imm(); return cv(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00); endfunction
  function automatic logic [15:0] x_ex_beq(input logic z);
    return cv(0, 0, 0, 0, 0, z, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
  endfunction
  function automatic logic [15:0] x_ex_j();   return cv(0,0,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b10); endfunction
  function automatic logic [15:0] x_mem_lw(); return cv(1,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [15:0] x_mem_sw(); return cv(1,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [15:0] x_wb_r();   return cv(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [15:0] x_wb_lw();  return cv(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [15:0] x_wb_ai();  return cv(0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00); endfunction

  task automatic test_reset();
    cyc_t p[$];
    cyc_t e;
    for (int k = 0; k < 3; k++) p.push_back(cy(0, 1, 1, OP_LW, 0, 3'd0, 16'h0, 0, 0, 2'b00));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL reset cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
    total++;
    if (CycleCnt !== 32'd0) $display("FAIL reset_cyclecnt: got %0d want 0", CycleCnt);
    else passed++;
    total++;
    if (RetireCnt !== 32'd0) $display("FAIL reset_retirecnt: got %0d want 0", RetireCnt);
    else passed++;
  endtask

  task automatic test_lw();
    cyc_t p[$];
    cyc_t e;
    p.push_back(cy(1, 1, 0, OP_LW, 0, 3'd0, x_if(1),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd1, x_id(),      0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd2, x_ex_imm(),  0, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_LW, 0, 3'd3, x_mem_lw(),  0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd4, x_wb_lw(),   1, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd0, x_if(0),     0, 0, 2'b00));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL lw cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
  endtask

  task automatic test_beq();
    cyc_t p[$];
    cyc_t e;
    p.push_back(cy(1, 1, 1, OP_BEQ, 0, 3'd0, x_if(1),        0, 0, 2'b00));
    p.push_back(cy(1, 0, 1, OP_BEQ, 0, 3'd1, x_id(),         0, 0, 2'b00));
    p.push_back(cy(1, 0, 1, OP_BEQ, 0, 3'd2, x_ex_beq(1'b1), 1, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_BEQ, 0, 3'd0, x_if(1),        0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_BEQ, 0, 3'd1, x_id(),         0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_BEQ, 0, 3'd2, x_ex_beq(1'b0), 1, 0, 2'b00));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL beq cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t p[$];
    cyc_t e;
    // R-type add, addi, j back to back; ID/EX/WB cycles see MemReady=0 and must not stall.
    p.push_back(cy(1, 1, 0, OP_R,    FN_ADD, 3'd0, x_if(1),    0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_R,    FN_ADD, 3'd1, x_id(),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_R,    FN_ADD, 3'd2, x_ex_r(),   0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_R,    FN_ADD, 3'd4, x_wb_r(),   1, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_ADDI, 0,      3'd0, x_if(1),    0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_ADDI, 0,      3'd1, x_id(),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_ADDI, 0,      3'd2, x_ex_imm(), 0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_ADDI, 0,      3'd4, x_wb_ai(),  1, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_J,    0,      3'd0, x_if(1),    0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_J,    0,      3'd1, x_id(),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_J,    0,      3'd2, x_ex_j(),   1, 0, 2'b00));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL b2b cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
  endtask

  task automatic test_sw_wait();
    cyc_t p[$];
    cyc_t e;
    p.push_back(cy(1, 1, 0, OP_SW, 0, 3'd0, x_if(1),    0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_SW, 0, 3'd1, x_id(),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_SW, 0, 3'd2, x_ex_imm(), 0, 0, 2'b00));
    // Three unanswered cycles, then MemReady on the cycle that would otherwise hit the limit of 4.
    for (int k = 0; k < 3; k++) p.push_back(cy(1, 0, 0, OP_SW, 0, 3'd3, x_mem_sw(), 0, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_SW, 0, 3'd3, x_mem_sw(), 1, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_SW, 0, 3'd0, x_if(0),    0, 0, 2'b00));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL sw_wait cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    cyc_t p[$];
    cyc_t e;
    p.push_back(cy(1, 1, 0, OP_BAD, 0, 3'd0, x_if(1), 0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_BAD, 0, 3'd1, x_id(),  0, 0, 2'b00));
    p.push_back(cy(1, 1, 1, OP_BAD, 0, 3'd7, 16'h0,   0, 1, 2'b01));
    p.push_back(cy(1, 0, 0, OP_LW,  0, 3'd7, 16'h0,   0, 1, 2'b01));
    p.push_back(cy(1, 1, 1, OP_J,   0, 3'd7, 16'h0,   0, 1, 2'b01));
    p.push_back(cy(0, 1, 0, OP_R,   FN_BAD, 3'd7, 16'h0, 0, 1, 2'b01));
    // R-type with an unsupported funct also faults.
    p.push_back(cy(1, 1, 0, OP_R,   FN_BAD, 3'd0, x_if(1), 0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_R,   FN_BAD, 3'd1, x_id(),  0, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_R,   FN_BAD, 3'd7, 16'h0,   0, 1, 2'b01));
    p.push_back(cy(0, 0, 0, OP_R,   FN_BAD, 3'd7, 16'h0,   0, 1, 2'b01));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL illegal cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    cyc_t p[$];
    cyc_t e;
    // Fetch never answered: four IF cycles, then HALT with the timeout code.
    for (int k = 0; k < 4; k++) p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd0, x_if(0), 0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd7, 16'h0, 0, 1, 2'b10));
    p.push_back(cy(1, 1, 0, OP_LW, 0, 3'd7, 16'h0, 0, 1, 2'b10));
    p.push_back(cy(0, 1, 0, OP_LW, 0, 3'd7, 16'h0, 0, 1, 2'b10));
    // Load whose data phase is never answered.
    p.push_back(cy(1, 1, 0, OP_LW, 0, 3'd0, x_if(1),    0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd1, x_id(),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd2, x_ex_imm(), 0, 0, 2'b00));
    for (int k = 0; k < 4; k++) p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd3, x_mem_lw(), 0, 0, 2'b00));
    p.push_back(cy(1, 1, 0, OP_LW, 0, 3'd7, 16'h0, 0, 1, 2'b10));
    p.push_back(cy(0, 0, 0, OP_LW, 0, 3'd7, 16'h0, 0, 1, 2'b10));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL timeout cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
    end
  endtask

  task automatic test_perf_and_mid_reset();
    cyc_t p[$];
    cyc_t e;
    logic [31:0] exp_cyc, exp_ret;
`ifdef PERF_CNT_EN
    exp_cyc = 32'd12;
    exp_ret = 32'd3;
`else
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
`endif
    // Entered straight after a reset edge: three addi take 12 counted cycles.
    for (int k = 0; k < 3; k++) begin
      p.push_back(cy(1, 1, 0, OP_ADDI, 0, 3'd0, x_if(1),    0, 0, 2'b00));
      p.push_back(cy(1, 0, 0, OP_ADDI, 0, 3'd1, x_id(),     0, 0, 2'b00));
      p.push_back(cy(1, 0, 0, OP_ADDI, 0, 3'd2, x_ex_imm(), 0, 0, 2'b00));
      p.push_back(cy(1, 0, 0, OP_ADDI, 0, 3'd4, x_wb_ai(),  1, 0, 2'b00));
    end
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd0, x_if(0),    0, 0, 2'b00));
    // Reset asserted while a load waits in MEM.
    p.push_back(cy(1, 1, 0, OP_LW, 0, 3'd0, x_if(1),    0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd1, x_id(),     0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd2, x_ex_imm(), 0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd3, x_mem_lw(), 0, 0, 2'b00));
    p.push_back(cy(0, 0, 0, OP_LW, 0, 3'd3, 16'h0,      0, 0, 2'b00));
    p.push_back(cy(1, 0, 0, OP_LW, 0, 3'd0, x_if(0),    0, 0, 2'b00));
    foreach (p[i]) begin
      @(posedge Clock); #1;
      Reset = p[i].rst; MemReady = p[i].rdy; Zero = p[i].zero; Opcode = p[i].op; Funct = p[i].fn;
      sb.push_back(p[i]);
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if ({State, obs_ctrl, Retire, Halted, FaultCode} !== {e.st, e.ctrl, e.ret, e.hlt, e.flt})
        $display("FAIL perf cyc%0d: st=%0d ctrl=%h ret=%b hlt=%b flt=%b want st=%0d ctrl=%h ret=%b hlt=%b flt=%b",
                 i, State, obs_ctrl, Retire, Halted, FaultCode, e.st, e.ctrl, e.ret, e.hlt, e.flt);
      else passed++;
      if (i == 12) begin
        total++;
        if (CycleCnt !== exp_cyc) $display("FAIL perf_cyclecnt: got %0d want %0d", CycleCnt, exp_cyc);
        else passed++;
        total++;
        if (RetireCnt !== exp_ret) $display("FAIL perf_retirecnt: got %0d want %0d", RetireCnt, exp_ret);
        else passed++;
      end
      if (i == p.size() - 1) begin
        total++;
        if (CycleCnt !== 32'd0) $display("FAIL perf_cyclecnt_cleared: got %0d want 0", CycleCnt);
        else passed++;
        total++;
        if (RetireCnt !== 32'd0) $display("FAIL perf_retirecnt_cleared: got %0d want 0", RetireCnt);
        else passed++;
      end
    end
  endtask

  initial begin
    Reset = 1'b0; MemReady = 1'b0; Zero = 1'b0; Opcode = 6'd0; Funct = 6'd0;
    test_reset();
    test_lw();
    test_beq();
    test_back_to_back();
    test_sw_wait();
    test_illegal();
    test_timeout();
    test_perf_and_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1);
  end

endmodule
